// File: rtl/ssram_responder_pkg.sv
// ssram_responder_pkg
// Shared definitions for the SSRAM bus responder.
// Holds the responder FSM state encoding, the SSRAM word-address width and
// the default read latency (SSRAM clocks from address issue to valid data).
package ssram_responder_pkg;

  localparam int SRAM_AW          = 20;
  localparam int DEFAULT_READ_LAT = 2;

  // IDLE  : waiting for a selected bus cycle
  // ISSUE : one cycle with the address strobe on the SSRAM pins
  // WAIT  : read pipeline delay, output enable held
  // DONE  : ready held until the bus master releases the request
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/ssram_responder.sv
// ssram_responder
// Bridges a simple chipselect/start bus cycle onto a synchronous SRAM.
// A selected start latches the request, one ISSUE cycle drives the SSRAM
// address strobe, reads then wait READ_LAT clocks before capturing sram_din,
// and ready is held in DONE until the master drops its request.
//
// Ports
//   clock, reset           : rising-edge clock, synchronous active-high reset
//   select, start          : chipselect bit and one-cycle start strobe
//   read, write            : bus request (write wins if both set)
//   be, address, writedata : byte enables, byte address, write data
//   readdata, ready        : registered read data, transfer-complete flag
//   sram_*                 : SSRAM address/data/strobe pins (strobes active-low)
module ssram_responder
  import ssram_responder_pkg::*;
#(
  parameter int unsigned READ_LAT = DEFAULT_READ_LAT
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               select,
  input  logic               start,
  input  logic               read,
  input  logic               write,
  input  logic [3:0]         be,
  input  logic [31:0]        address,
  input  logic [31:0]        writedata,
  output logic [31:0]        readdata,
  output logic               ready,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [31:0]        sram_dout,
  output logic               sram_doe,
  input  logic [31:0]        sram_din,
  output logic               sram_ce_n,
  output logic               sram_adsc_n,
  output logic               sram_we_n,
  output logic               sram_oe_n,
  output logic [3:0]         sram_be_n
);

  localparam logic [2:0] CNT_LOAD = 3'(READ_LAT - 1);

  state_t             state, next_state;
  logic [SRAM_AW-1:0] addr_q;
  logic [3:0]         be_q;
  logic [31:0]        data_q;
  logic               op_write;
  logic [2:0]         cnt;
  logic [31:0]        readdata_q;
  logic               accept;
  logic               capture;
  logic               op_active;

  // Byte-lane and high address bits are not decoded by this target.
  logic unused_address_bits;
  assign unused_address_bits = ^{address[31:22], address[1:0]};

  // State register; reset always lands in IDLE so no strobe survives it.
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Next-state logic. An abort (select or the latched op's request dropping)
  // in ISSUE or WAIT returns straight to IDLE without capturing read data.
  always_comb begin
    next_state = state;
    accept     = 1'b0;
    capture    = 1'b0;
    op_active  = op_write ? write : read;
    case (state)
      IDLE: begin
        if (select && start && (read || write)) begin
          accept     = 1'b1;
          next_state = ISSUE;
        end
      end
      ISSUE: begin
        if (!select || !op_active) next_state = IDLE;
        else if (op_write)         next_state = DONE;
        else                       next_state = WAIT;
      end
      WAIT: begin
        if (!select || !op_active) next_state = IDLE;
        else if (cnt == 3'd0) begin
          capture    = 1'b1;
          next_state = DONE;
        end
      end
      DONE: begin
        if (!select || (!read && !write)) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Request latch, latency counter and read-data capture. The counter is
  // loaded on the ISSUE->WAIT transition so WAIT lasts exactly READ_LAT clocks.
  always_ff @(posedge clock) begin
    if (reset) begin
      addr_q     <= '0;
      be_q       <= '0;
      data_q     <= '0;
      op_write   <= 1'b0;
      cnt        <= '0;
      readdata_q <= '0;
    end else begin
      if (accept) begin
        addr_q   <= address[21:2];
        be_q     <= be;
        data_q   <= writedata;
        op_write <= write;
      end
      if (state == ISSUE && next_state == WAIT) cnt <= CNT_LOAD;
      else if (state == WAIT && cnt != 3'd0)    cnt <= cnt - 3'd1;
      if (capture) readdata_q <= sram_din;
    end
  end

  // Pin decode uses only state and latched registers, so no bus input ever
  // reaches an output combinationally. Output enable is only given for reads,
  // so sram_doe and sram_oe_n=0 are mutually exclusive by construction.
  assign ready       = (state == DONE);
  assign readdata    = readdata_q;
  assign sram_addr   = addr_q;
  assign sram_dout   = data_q;
  assign sram_doe    = (state == ISSUE) && op_write;
  assign sram_ce_n   = !((state == ISSUE) || (state == WAIT));
  assign sram_adsc_n = (state != ISSUE);
  assign sram_we_n   = !((state == ISSUE) && op_write);
  assign sram_oe_n   = !(((state == ISSUE) && !op_write) || (state == WAIT));
  assign sram_be_n   = (state == ISSUE) ? ~be_q : 4'hF;

endmodule

// File: tb/tb_ssram_responder.sv
// tb_ssram_responder
// Directed bench for ssram_responder. Three instances share the bus stimulus
// (READ_LAT = 2, 1, 7); the READ_LAT=2 instance is the one checked in detail,
// the other two are used to confirm ready latency for the extreme settings.
module tb_ssram_responder;
  import ssram_responder_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        select = 1'b0, start = 1'b0, read = 1'b0, write = 1'b0;
  logic [3:0]  be = 4'h0;
  logic [31:0] address = '0, writedata = '0, sram_din = '0;

  logic [31:0] readdata2, readdata1, readdata7;
  logic        ready2, ready1, ready7;
  logic [19:0] sram_addr2, sram_addr1, sram_addr7;
  logic [31:0] sram_dout2, sram_dout1, sram_dout7;
  logic        sram_doe2, sram_doe1, sram_doe7;
  logic        ce_n2, ce_n1, ce_n7, adsc_n2, adsc_n1, adsc_n7;
  logic        we_n2, we_n1, we_n7, oe_n2, oe_n1, oe_n7;
  logic [3:0]  be_n2, be_n1, be_n7;

  int checks = 0;
  int errors = 0;

  // 100 MHz-style free-running clock
  always #5 clock = ~clock;

  ssram_responder #(.READ_LAT(2)) dut (
    .clock(clock), .reset(reset), .select(select), .start(start), .read(read),
    .write(write), .be(be), .address(address), .writedata(writedata),
    .readdata(readdata2), .ready(ready2), .sram_addr(sram_addr2),
    .sram_dout(sram_dout2), .sram_doe(sram_doe2), .sram_din(sram_din),
    .sram_ce_n(ce_n2), .sram_adsc_n(adsc_n2), .sram_we_n(we_n2),
    .sram_oe_n(oe_n2), .sram_be_n(be_n2));

  ssram_responder #(.READ_LAT(1)) dut_lat1 (
    .clock(clock), .reset(reset), .select(select), .start(start), .read(read),
    .write(write), .be(be), .address(address), .writedata(writedata),
    .readdata(readdata1), .ready(ready1), .sram_addr(sram_addr1),
    .sram_dout(sram_dout1), .sram_doe(sram_doe1), .sram_din(sram_din),
    .sram_ce_n(ce_n1), .sram_adsc_n(adsc_n1), .sram_we_n(we_n1),
    .sram_oe_n(oe_n1), .sram_be_n(be_n1));

  ssram_responder #(.READ_LAT(7)) dut_lat7 (
    .clock(clock), .reset(reset), .select(select), .start(start), .read(read),
    .write(write), .be(be), .address(address), .writedata(writedata),
    .readdata(readdata7), .ready(ready7), .sram_addr(sram_addr7),
    .sram_dout(sram_dout7), .sram_doe(sram_doe7), .sram_din(sram_din),
    .sram_ce_n(ce_n7), .sram_adsc_n(adsc_n7), .sram_we_n(we_n7),
    .sram_oe_n(oe_n7), .sram_be_n(be_n7));

  // Advance one clock and settle just after the edge
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    $display("[TB] test_reset");
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    checks++; if (ready2 !== 1'b0) begin errors++; $display("[TB] FAIL reset_ready got %0b want 0", ready2); end
    checks++; if (readdata2 !== 32'h0) begin errors++; $display("[TB] FAIL reset_readdata got %h want 0", readdata2); end
    checks++; if ({ce_n2, adsc_n2, we_n2, oe_n2} !== 4'b1111) begin errors++; $display("[TB] FAIL reset_strobes got %b want 1111", {ce_n2, adsc_n2, we_n2, oe_n2}); end
    checks++; if (be_n2 !== 4'hF) begin errors++; $display("[TB] FAIL reset_be_n got %b want 1111", be_n2); end
    checks++; if (sram_doe2 !== 1'b0) begin errors++; $display("[TB] FAIL reset_doe got %0b want 0", sram_doe2); end
    checks++; if (sram_addr2 !== 20'h0) begin errors++; $display("[TB] FAIL reset_addr got %h want 0", sram_addr2); end
    checks++; if (sram_dout2 !== 32'h0) begin errors++; $display("[TB] FAIL reset_dout got %h want 0", sram_dout2); end
    checks++; if (dut.state !== IDLE) begin errors++; $display("[TB] FAIL reset_state got %0d want %0d", dut.state, IDLE); end
    checks++; if (dut.cnt !== 3'd0) begin errors++; $display("[TB] FAIL reset_cnt got %0d want 0", dut.cnt); end
  endtask

  task automatic test_read_latency();
    int lat2, lat1, lat7;
    $display("[TB] test_read_latency");
    sram_din = 32'hDEADBEEF;
    address  = 32'h0000_1234;
    select = 1'b1; read = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    checks++; if (sram_addr2 !== 20'h0048D) begin errors++; $display("[TB] FAIL read_issue_addr got %h want 0048d", sram_addr2); end
    checks++; if ({ce_n2, adsc_n2, we_n2, oe_n2} !== 4'b0010) begin errors++; $display("[TB] FAIL read_issue_strobes got %b want 0010", {ce_n2, adsc_n2, we_n2, oe_n2}); end
    checks++; if (sram_doe2 !== 1'b0) begin errors++; $display("[TB] FAIL read_issue_doe got %0b want 0", sram_doe2); end
    lat2 = 0; lat1 = 0; lat7 = 0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (lat2 == 0 && ready2 === 1'b1) lat2 = i;
      if (lat1 == 0 && ready1 === 1'b1) lat1 = i;
      if (lat7 == 0 && ready7 === 1'b1) lat7 = i;
    end
    checks++; if (lat2 != 3) begin errors++; $display("[TB] FAIL read_latency_2 got %0d want 3", lat2); end
    checks++; if (lat1 != 2) begin errors++; $display("[TB] FAIL read_latency_1 got %0d want 2", lat1); end
    checks++; if (lat7 != 8) begin errors++; $display("[TB] FAIL read_latency_7 got %0d want 8", lat7); end
    checks++; if (readdata2 !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL read_data_2 got %h want deadbeef", readdata2); end
    checks++; if (readdata1 !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL read_data_1 got %h want deadbeef", readdata1); end
    checks++; if (readdata7 !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL read_data_7 got %h want deadbeef", readdata7); end
    read = 1'b0;
    tick();
    checks++; if (ready2 !== 1'b0) begin errors++; $display("[TB] FAIL read_release_ready got %0b want 0", ready2); end
    checks++; if (dut.state !== IDLE) begin errors++; $display("[TB] FAIL read_release_state got %0d want %0d", dut.state, IDLE); end
  endtask

  task automatic test_write();
    $display("[TB] test_write");
    address = 32'h0000_0010; be = 4'b0101; writedata = 32'hA5A5A5A5;
    select = 1'b1; write = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    checks++; if ({ce_n2, adsc_n2, we_n2, oe_n2} !== 4'b0001) begin errors++; $display("[TB] FAIL write_issue_strobes got %b want 0001", {ce_n2, adsc_n2, we_n2, oe_n2}); end
    checks++; if (be_n2 !== 4'b1010) begin errors++; $display("[TB] FAIL write_be_n got %b want 1010", be_n2); end
    checks++; if (sram_dout2 !== 32'hA5A5A5A5) begin errors++; $display("[TB] FAIL write_dout got %h want a5a5a5a5", sram_dout2); end
    checks++; if (sram_addr2 !== 20'h00004) begin errors++; $display("[TB] FAIL write_addr got %h want 00004", sram_addr2); end
    checks++; if (sram_doe2 !== 1'b1) begin errors++; $display("[TB] FAIL write_doe got %0b want 1", sram_doe2); end
    checks++; if (ready2 !== 1'b0) begin errors++; $display("[TB] FAIL write_issue_ready got %0b want 0", ready2); end
    tick();
    checks++; if (ready2 !== 1'b1) begin errors++; $display("[TB] FAIL write_done_ready got %0b want 1", ready2); end
    checks++; if ({we_n2, sram_doe2, ce_n2} !== 3'b101) begin errors++; $display("[TB] FAIL write_done_pins got %b want 101", {we_n2, sram_doe2, ce_n2}); end
    write = 1'b0;
    tick();
    checks++; if (ready2 !== 1'b0) begin errors++; $display("[TB] FAIL write_release_ready got %0b want 0", ready2); end
  endtask

  task automatic test_zero_be();
    $display("[TB] test_zero_be");
    address = 32'h0000_0008; be = 4'b0000; writedata = 32'h01020304;
    select = 1'b1; write = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    checks++; if ({we_n2, be_n2} !== 5'b0_1111) begin errors++; $display("[TB] FAIL zero_be_issue got %b want 01111", {we_n2, be_n2}); end
    tick();
    checks++; if (ready2 !== 1'b1) begin errors++; $display("[TB] FAIL zero_be_ready got %0b want 1", ready2); end
    write = 1'b0;
    tick();
  endtask

  task automatic test_abort();
    int seen_ready;
    $display("[TB] test_abort");
    sram_din = 32'h11111111;
    address = 32'h0000_0040;
    select = 1'b1; read = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    checks++; if (dut.state !== WAIT) begin errors++; $display("[TB] FAIL abort_in_wait got %0d want %0d", dut.state, WAIT); end
    checks++; if ({ce_n2, oe_n2} !== 2'b00) begin errors++; $display("[TB] FAIL abort_wait_pins got %b want 00", {ce_n2, oe_n2}); end
    read = 1'b0;
    seen_ready = 0;
    tick();
    checks++; if (dut.state !== IDLE) begin errors++; $display("[TB] FAIL abort_state got %0d want %0d", dut.state, IDLE); end
    checks++; if ({ce_n2, oe_n2} !== 2'b11) begin errors++; $display("[TB] FAIL abort_pins got %b want 11", {ce_n2, oe_n2}); end
    for (int i = 0; i < 4; i++) begin
      if (ready2 === 1'b1) seen_ready++;
      tick();
    end
    checks++; if (seen_ready != 0) begin errors++; $display("[TB] FAIL abort_ready_seen got %0d want 0", seen_ready); end
    checks++; if (readdata2 !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL abort_readdata got %h want deadbeef", readdata2); end
  endtask

  task automatic test_back_to_back();
    int lat;
    $display("[TB] test_back_to_back");
    sram_din = 32'hCAFEF00D;
    address = 32'h0000_0100;
    select = 1'b1; read = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    checks++; if (sram_addr2 !== 20'h00040) begin errors++; $display("[TB] FAIL b2b_addr1 got %h want 00040", sram_addr2); end
    lat = 0;
    for (int i = 1; i <= 10 && lat == 0; i++) begin
      tick();
      if (ready2 === 1'b1) lat = i;
    end
    checks++; if (lat != 3) begin errors++; $display("[TB] FAIL b2b_latency1 got %0d want 3", lat); end
    checks++; if (readdata2 !== 32'hCAFEF00D) begin errors++; $display("[TB] FAIL b2b_data1 got %h want cafef00d", readdata2); end
    address = 32'h0000_0200; start = 1'b1;
    tick();
    start = 1'b0;
    checks++; if ({ready2, ce_n2, adsc_n2} !== 3'b111) begin errors++; $display("[TB] FAIL b2b_start_ignored got %b want 111", {ready2, ce_n2, adsc_n2}); end
    checks++; if (dut.state !== DONE) begin errors++; $display("[TB] FAIL b2b_still_done got %0d want %0d", dut.state, DONE); end
    read = 1'b0;
    tick();
    checks++; if (dut.state !== IDLE) begin errors++; $display("[TB] FAIL b2b_release got %0d want %0d", dut.state, IDLE); end
    sram_din = 32'h0BADF00D;
    read = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    checks++; if (sram_addr2 !== 20'h00080) begin errors++; $display("[TB] FAIL b2b_addr2 got %h want 00080", sram_addr2); end
    lat = 0;
    for (int i = 1; i <= 10 && lat == 0; i++) begin
      tick();
      if (ready2 === 1'b1) lat = i;
    end
    checks++; if (lat != 3) begin errors++; $display("[TB] FAIL b2b_latency2 got %0d want 3", lat); end
    checks++; if (readdata2 !== 32'h0BADF00D) begin errors++; $display("[TB] FAIL b2b_data2 got %h want 0badf00d", readdata2); end
    read = 1'b0;
    tick();
  endtask

  task automatic test_reset_in_issue();
    $display("[TB] test_reset_in_issue");
    address = 32'h0000_0020; be = 4'hF; writedata = 32'h12345678;
    select = 1'b1; write = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    checks++; if (we_n2 !== 1'b0) begin errors++; $display("[TB] FAIL rst_issue_we got %0b want 0", we_n2); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++; if ({ce_n2, adsc_n2, we_n2, oe_n2, be_n2} !== 8'hFF) begin errors++; $display("[TB] FAIL rst_issue_strobes got %b want 11111111", {ce_n2, adsc_n2, we_n2, oe_n2, be_n2}); end
    checks++; if ({sram_doe2, ready2} !== 2'b00) begin errors++; $display("[TB] FAIL rst_issue_doe_ready got %b want 00", {sram_doe2, ready2}); end
    checks++; if (dut.state !== IDLE) begin errors++; $display("[TB] FAIL rst_issue_state got %0d want %0d", dut.state, IDLE); end
    checks++; if (readdata2 !== 32'h0) begin errors++; $display("[TB] FAIL rst_issue_readdata got %h want 0", readdata2); end
    tick();
    checks++; if ({we_n2, dut.state} !== {1'b1, IDLE}) begin errors++; $display("[TB] FAIL rst_issue_after got %b want 100", {we_n2, dut.state}); end
    write = 1'b0; select = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_read_latency();
    test_write();
    test_zero_be();
    test_abort();
    test_back_to_back();
    test_reset_in_issue();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ssram_responder.md
SSRAM_RESPONDER -- requirements
Module: ssram_responder

Interface
REQ-001 The block SHALL have a single clock `clock`; reset is synchronous and active-high, port `reset`.
REQ-002 Parameter `READ_LAT`, default 2: SSRAM clocks from address issue to valid read data, legal range 1..7.
REQ-003 Ports, with direction, width and meaning, SHALL be:
- `clock` in 1: rising-edge clock.
- `reset` in 1: synchronous active-high reset.
- `select` in 1: this target's chipselect bit from the bus controller.
- `start` in 1: one-cycle bus-cycle start strobe.
- `read` in 1: bus read request.
- `write` in 1: bus write request.
- `be` in 4: byte enables, bit 0 = data[7:0].
- `address` in 32: byte address.
- `writedata` in 32: bus write data.
- `readdata` out 32: registered read data.
- `ready` out 1: transfer complete, held until release.
- `sram_addr` out 20: SSRAM word address.
- `sram_dout` out 32: data to SSRAM.
- `sram_doe` out 1: data bus output enable.
- `sram_din` in 32: data from SSRAM.
- `sram_ce_n` out 1: chip enable, active-low.
- `sram_adsc_n` out 1: address strobe, active-low.
- `sram_we_n` out 1: write enable, active-low.
- `sram_oe_n` out 1: output enable, active-low.
- `sram_be_n` out 4: byte write enables, active-low.

Function
REQ-004 The FSM SHALL have states IDLE, ISSUE, WAIT and DONE, with exactly one state active per cycle.
REQ-005 IDLE: when `select && start && (read || write)`, the block SHALL latch `address[21:2]`, `be`, `writedata` and op (write wins if both set), then go to ISSUE; otherwise it stays in IDLE.
REQ-006 ISSUE (1 cycle) SHALL drive `sram_ce_n`=0 and `sram_adsc_n`=0, `sram_addr` = latched word address, `sram_be_n` = ~latched be.
- Write: `sram_we_n`=0, `sram_doe`=1, `sram_dout` = latched data, next state DONE.
- Read: `sram_we_n`=1, `sram_oe_n`=0, next state WAIT.
REQ-007 WAIT SHALL hold `sram_oe_n`=0 and `sram_ce_n`=0, and load a 3-bit counter with READ_LAT-1 on ISSUE exit.
- Counter ≠ 0: decrement.
- Counter = 0: register `sram_din` into `readdata` and go to DONE.
- Read latency SHALL be exactly READ_LAT+1 clocks from ISSUE to `ready`.
REQ-008 DONE: `ready`=1.
- When `read` and `write` are both 0, or `select`=0: go to IDLE and drop `ready` in the next cycle.
REQ-009 Abort: if `select` or the active op request drops in ISSUE or WAIT, the block SHALL return to IDLE next cycle, never assert `ready`, and leave `readdata` unchanged.
REQ-010 `start` while not in IDLE SHALL be ignored.
REQ-011 A write with `be`=0000 SHALL still run a full cycle with `sram_be_n`=1111.
REQ-012 Outside ISSUE and WAIT, all SSRAM strobes SHALL be inactive (1) and `sram_doe` SHALL be 0.
REQ-013 `sram_doe` and `sram_oe_n`=0 SHALL never be asserted in the same cycle.
REQ-014 All outputs SHALL be registered or decoded from state only, with no combinational path from bus inputs to outputs.

Reset
REQ-015 When `reset`=1 at a clock edge, the block SHALL enter IDLE with:
- `ready`=0 and `readdata`=0.
- Counter = 0.
- `sram_ce_n`, `sram_adsc_n`, `sram_we_n` and `sram_oe_n` = 1; `sram_be_n`=1111.
- `sram_doe`=0, `sram_addr`=0 and `sram_dout`=0.
REQ-016 Reset mid-transfer SHALL abort the transfer with no SSRAM write strobe issued after the reset edge.

Structure
REQ-017 A shared package SHALL hold the FSM state enum, the SSRAM address width (20) and the default READ_LAT.
REQ-018 The block is a single module with no sub-module; the latency counter is inline.

Verification
REQ-019 Read, READ_LAT=2: address=0x00001234, sram_din=0xDEADBEEF → sram_addr=0x0048D, `ready` 3 clocks after ISSUE, readdata=0xDEADBEEF.
REQ-020 Write: address=0x00000010, be=0101, writedata=0xA5A5A5A5 → one ISSUE cycle with sram_we_n=0, sram_be_n=1010, sram_dout=0xA5A5A5A5, sram_addr=0x00004, then `ready`.
REQ-021 Abort: read started, `read` dropped in WAIT → back in IDLE, `ready` never 1, readdata keeps its prior value.
REQ-022 Reset asserted in ISSUE of a write → next cycle all strobes inactive, sram_doe=0, state IDLE.
REQ-023 Back-to-back: two reads with release between them, plus `start` pulsed during DONE → the second `start` is ignored until IDLE; each read returns its own data.
REQ-024 READ_LAT=1 and READ_LAT=7 builds → `ready` 2 and 8 clocks after ISSUE respectively.
